// File: rtl/ascon_pkg.sv
// Shared ASCON permutation types: 320-bit state, 5-bit S-box table, p_S FSM encoding.
package ascon_pkg;

    typedef logic [4:0][63:0] type_state;

    localparam logic [4:0] sub_constant [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} ps_fsm_t;

    function automatic int ps_latency(input int cols);
        return 64 / cols + 1;
    endfunction

endpackage

// File: rtl/sbox_layer_serial_if.sv
// Handshake bus of the serial p_S layer; ASCON_PS_BYPASS_EN adds the bypass_i sideband.
interface sbox_layer_serial_if;
    import ascon_pkg::*;

    logic      in_valid_i;
    logic      in_ready_o;
    type_state state_i;
    logic      out_valid_o;
    logic      out_ready_i;
    type_state state_o;
`ifdef ASCON_PS_BYPASS_EN
    logic      bypass_i;
`endif

    modport slave (
`ifdef ASCON_PS_BYPASS_EN
        input  bypass_i,
`endif
        input  in_valid_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o
    );

    modport master (
`ifdef ASCON_PS_BYPASS_EN
        output bypass_i,
`endif
        output in_valid_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o
    );

endinterface

// File: rtl/sbox.sv
// Single 5-bit ASCON S-box lookup; bit 4 of din/dout is the x0 row.
module sbox
    import ascon_pkg::*;
(
    input  logic [4:0] din,
    output logic [4:0] dout
);
    assign dout = sub_constant[din];
endmodule

// File: rtl/sbox_layer_serial.sv
// Serialised ASCON p_S: COLS_PER_CYCLE S-boxes walk the 64 state columns in place.
// Optional macro ASCON_PS_BYPASS_EN: bus.bypass_i sends an accepted state straight to DONE.
module sbox_layer_serial
    import ascon_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    sbox_layer_serial_if.slave bus
);
    localparam int          NGRP  = ps_latency(COLS_PER_CYCLE) - 1;
    localparam int          CW    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [63:0] GMASK = 64'({COLS_PER_CYCLE{1'b1}});

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4 &&
        COLS_PER_CYCLE != 8 && COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
        COLS_PER_CYCLE != 64) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be a power of two between 1 and 64");
    end

    ps_fsm_t                         fsm, fsm_nxt;
    logic [CW-1:0]                   cnt;
    logic                            last, accept, bypass;
    logic [5:0]                      base;
    type_state                       work, work_run, st_out;
    logic [4:0][COLS_PER_CYCLE-1:0]  grp_in, grp_out;
    logic [COLS_PER_CYCLE-1:0][4:0]  sb_in, sb_out;
    logic                            in_rdy, out_vld, rdy_nxt, vld_nxt, load_out;

`ifdef ASCON_PS_BYPASS_EN
    assign bypass = bus.bypass_i;
`else
    assign bypass = 1'b0;
`endif

    assign accept = (fsm == IDLE) && bus.in_valid_i;
    assign last   = (cnt == CW'(NGRP - 1));
    assign base   = 6'(int'(cnt) * COLS_PER_CYCLE);

    // Shift/mask instead of a variable part-select keeps COLS_PER_CYCLE = 64 in range.
    for (genvar k = 0; k < 5; k++) begin : g_row
        assign grp_in[k]   = COLS_PER_CYCLE'(work[k] >> base);
        assign work_run[k] = (work[k] & ~(GMASK << base)) | (64'(grp_out[k]) << base);
    end

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
        assign sb_in[i] = {grp_in[0][i], grp_in[1][i], grp_in[2][i], grp_in[3][i], grp_in[4][i]};
        sbox u_sbox (.din(sb_in[i]), .dout(sb_out[i]));
        for (genvar k = 0; k < 5; k++) begin : g_bit
            assign grp_out[k][i] = sb_out[i][4-k];
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) fsm <= IDLE;
        else           fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (bus.in_valid_i) fsm_nxt = bypass ? DONE : RUN;
            RUN:     if (last) fsm_nxt = DONE;
            DONE:    if (out_vld && bus.out_ready_i) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Result registers are loaded on the first DONE cycle, so valid trails the FSM by one clock.
    always_comb begin
        rdy_nxt  = (fsm_nxt == IDLE);
        vld_nxt  = (fsm == DONE) && !(out_vld && bus.out_ready_i);
        load_out = (fsm == DONE) && !out_vld;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt  <= '0;
            work <= '0;
        end else if (accept) begin
            cnt  <= '0;
            work <= bus.state_i;
        end else if (fsm == RUN) begin
            work <= work_run;
            if (!last) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
            st_out  <= '0;
        end else begin
            in_rdy  <= rdy_nxt;
            out_vld <= vld_nxt;
            if (load_out) st_out <= work;
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = out_vld;
    assign bus.state_o     = st_out;

endmodule
